// File: rtl/srt4_ctrl_pkg.sv
// Shared definitions for the SRT radix-4 divider control path counters.
// Holds the default channel widths and the request priority encoding.
package srt4_ctrl_pkg;

  localparam int ITER_CNT_W  = 2;
  localparam int SHIFT_CNT_W = 3;

  // Last quotient-digit iteration index of the radix-4 loop.
  localparam int ITER_TERM   = 3;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4
  } cnt_op_t;

  // clr beats load; inc and dec together cancel out to a hold.
  function automatic cnt_op_t decode_op(
    input logic clr,
    input logic load,
    input logic inc,
    input logic dec
  );
    cnt_op_t op;
    if (clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (inc && dec) begin
      op = OP_HOLD;
    end else if (inc) begin
      op = OP_INC;
    end else if (dec) begin
      op = OP_DEC;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/srt4_cnt_next.sv
// Next-state logic for one step-counter channel: new count value,
// overflow/underflow set requests and terminal-value entry detection.
module srt4_cnt_next
  import srt4_ctrl_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SATURATE = 0,
  parameter int TERM_VAL = 3
) (
  input  cnt_op_t          op,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             ovf_set,
  output logic             unf_set,
  output logic             term_entry
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(TERM_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               SAT     = (SATURATE != 0);

  always_comb begin
    next_count = count;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    unique case (op)
      OP_CLR: begin
        next_count = '0;
      end
      OP_LOAD: begin
        next_count = load_val;
      end
      OP_INC: begin
        if (count == MAX_VAL) begin
          ovf_set    = 1'b1;
          next_count = SAT ? MAX_VAL : '0;
        end else begin
          next_count = count + ONE;
        end
      end
      OP_DEC: begin
        if (count == '0) begin
          unf_set    = 1'b1;
          next_count = SAT ? '0 : MAX_VAL;
        end else begin
          next_count = count - ONE;
        end
      end
      default: begin
        next_count = count;
      end
    endcase
  end

  // A clear landing on TERM_VAL==0 is a restart, not an arrival.
  assign term_entry = (op != OP_CLR) && (next_count == TERM) && (count != TERM);

endmodule

// File: rtl/srt4_step_counter.sv
// Configurable up/down step counter for the SRT radix-4 divider controller;
// one instance per count channel (iteration count, normalisation shift).
module srt4_step_counter
  import srt4_ctrl_pkg::*;
#(
  parameter int WIDTH    = SHIFT_CNT_W,
  parameter int SATURATE = 0,
  parameter int TERM_VAL = ITER_TERM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             at_term,
  output logic             term_pulse,
  output logic             ovf,
  output logic             unf
);

  if (WIDTH < 1) begin : g_bad_width
    $error("srt4_step_counter: WIDTH must be at least 1");
  end

  if ((TERM_VAL < 0) || (TERM_VAL >= (1 << WIDTH))) begin : g_bad_term
    $error("srt4_step_counter: TERM_VAL must fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERM_VAL);

  cnt_op_t          op;
  logic [WIDTH-1:0] next_count;
  logic             ovf_set;
  logic             unf_set;
  logic             term_entry;

  assign op = decode_op(clr, load, inc, dec);

  srt4_cnt_next #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE),
    .TERM_VAL (TERM_VAL)
  ) u_next (
    .op         (op),
    .count      (count),
    .load_val   (load_val),
    .next_count (next_count),
    .ovf_set    (ovf_set),
    .unf_set    (unf_set),
    .term_entry (term_entry)
  );

  // Flags are sticky until clr or reset; load leaves them alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      term_pulse <= 1'b0;
    end else begin
      count      <= next_count;
      term_pulse <= term_entry;
      if (op == OP_CLR) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        ovf <= ovf | ovf_set;
        unf <= unf | unf_set;
      end
    end
  end

  assign at_term = (count == TERM);

endmodule
